// File: rtl/program_counter_ras_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program counter with return-address
// stack: default parameter values, the next-PC source select, the controller
// state encoding and a sign-extension helper for the branch/jump offsets.
// -----------------------------------------------------------------------------
package pc_pkg;

   localparam int PC_W_DEF        = 16;
   localparam int INSTR_BYTES_DEF = 2;
   localparam int BR_IMM_W_DEF    = 6;
   localparam int JMP_IMM_W_DEF   = 12;
   localparam int RAS_DEPTH_DEF   = 4;

   // Source of the next PC; exactly one is chosen per advancing edge.
   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_RET
   } next_sel_e;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_e;

   // Sign-extends the low 'width' bits of value to 32 bits. Callers truncate
   // the result to PC_W, so PC_W must not exceed 32.
   function automatic logic [31:0] sign_extend(input logic [31:0] value,
                                                input int unsigned width);
      logic [31:0] shifted;
      shifted = value << (32 - width);
      return 32'($signed(shifted) >>> (32 - width));
   endfunction

endpackage

// File: rtl/program_counter_ras_if.sv
// -----------------------------------------------------------------------------
// program_counter_ras_if
// Bundles the control requests coming from decode/execute and the status
// returned by the program counter.
//   master : decode/execute side (drives requests, observes PC and status)
//   slave  : program counter side
// Signals:
//   clk_en_pi           advance enable (0 holds all state)
//   halt_pi             enter HALTED
//   branch_taken_pi     take PC-relative branch by branch_immediate_pi
//   jump_taken_pi       take PC-relative jump by jump_immediate_pi
//   call_pi             with a selected jump, push the return address
//   ret_pi              pop the return-address stack and go there
//   clear_flags_pi      clear sticky overflow/underflow flags
//   pc_po               current PC / instruction-memory address
//   halted_po           1 while HALTED
//   ras_count_po        valid return-address stack entries
//   ras_overflow_po     sticky: push while full
//   ras_underflow_po    sticky: pop while empty
// -----------------------------------------------------------------------------
interface program_counter_ras_if #(
   parameter int PC_W      = 16,
   parameter int BR_IMM_W  = 6,
   parameter int JMP_IMM_W = 12,
   parameter int CNT_W     = 3
);

   logic                 clk_en_pi;
   logic                 halt_pi;
   logic                 branch_taken_pi;
   logic [BR_IMM_W-1:0]  branch_immediate_pi;
   logic                 jump_taken_pi;
   logic [JMP_IMM_W-1:0] jump_immediate_pi;
   logic                 call_pi;
   logic                 ret_pi;
   logic                 clear_flags_pi;

   logic [PC_W-1:0]      pc_po;
   logic                 halted_po;
   logic [CNT_W-1:0]     ras_count_po;
   logic                 ras_overflow_po;
   logic                 ras_underflow_po;

   modport master (
      output clk_en_pi, halt_pi, branch_taken_pi, branch_immediate_pi,
             jump_taken_pi, jump_immediate_pi, call_pi, ret_pi, clear_flags_pi,
      input  pc_po, halted_po, ras_count_po, ras_overflow_po, ras_underflow_po
   );

   modport slave (
      input  clk_en_pi, halt_pi, branch_taken_pi, branch_immediate_pi,
             jump_taken_pi, jump_immediate_pi, call_pi, ret_pi, clear_flags_pi,
      output pc_po, halted_po, ras_count_po, ras_overflow_po, ras_underflow_po
   );

endinterface

// File: rtl/program_counter_ras_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. ptr is the next write slot, so the top of
// stack sits at ptr-1. When full, a push lands on the slot holding the oldest
// entry, silently overwriting it, and count saturates at RAS_DEPTH. A pop
// while empty is ignored; the parent records the underflow.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write push_data as the new top
//   pop              discard the top entry
//   top              current top entry (don't-care while empty)
//   count            valid entries, 0..RAS_DEPTH
//   full, empty      count == RAS_DEPTH / count == 0
// The parent never asserts push and pop together.
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int PC_W      = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [PC_W-1:0]              push_data,
   input  logic                         pop,
   output logic [PC_W-1:0]              top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_pop;

   assign full   = (cnt == CNT_W'(RAS_DEPTH));
   assign empty  = (cnt == '0);
   assign count  = cnt;
   assign top    = mem[ptr - PTR_W'(1)];
   assign do_pop = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) cnt <= cnt + CNT_W'(1);
      end else if (do_pop) begin
         ptr <= ptr - PTR_W'(1);
         cnt <= cnt - CNT_W'(1);
      end
   end

   // NOTE: the storage array has no reset; its contents are meaningless
   // until pushed, and leaving it out of the reset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= push_data;
   end

endmodule

// File: rtl/program_counter_ras.sv
// -----------------------------------------------------------------------------
// program_counter_ras
// Fetch-stage program counter. Each enabled edge in RUN selects the next PC by
// priority: return (pop RAS), branch, jump (optionally pushing the return
// address for a call), sequential. halt_pi parks the PC in HALTED until reset;
// only the sticky flags can still be cleared there. All PC arithmetic wraps
// modulo 2^PC_W.
// Ports:
//   clk_pi      clock, rising edge
//   reset_n_pi  asynchronous active-low reset
//   bus         program_counter_ras_if.slave (requests in, PC/status out)
// -----------------------------------------------------------------------------
module program_counter_ras
   import pc_pkg::*;
#(
   parameter int          PC_W         = PC_W_DEF,
   parameter int          INSTR_BYTES  = INSTR_BYTES_DEF,
   parameter int          BR_IMM_W     = BR_IMM_W_DEF,
   parameter int          JMP_IMM_W    = JMP_IMM_W_DEF,
   parameter int          RAS_DEPTH    = RAS_DEPTH_DEF,
   parameter int unsigned RESET_VECTOR = 0
) (
   input  logic                   clk_pi,
   input  logic                   reset_n_pi,
   program_counter_ras_if.slave   bus
);

   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   state_e           state;
   logic [PC_W-1:0]  pc_q;
   logic             ovf_q;
   logic             unf_q;

   next_sel_e        sel;
   logic [PC_W-1:0]  pc_next;
   logic [PC_W-1:0]  pc_seq;
   logic [PC_W-1:0]  br_off;
   logic [PC_W-1:0]  jmp_off;
   logic             advance;
   logic             push;
   logic             pop;
   logic             set_ovf;
   logic             set_unf;

   logic [PC_W-1:0]  ras_top;
   logic [CNT_W-1:0] ras_count;
   logic             ras_full;
   logic             ras_empty;

   ras_stack #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk_pi),
      .rst_n     (reset_n_pi),
      .push      (push),
      .push_data (pc_seq),
      .pop       (pop),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign pc_seq  = pc_q + PC_W'(INSTR_BYTES);
   assign br_off  = PC_W'(sign_extend(32'(bus.branch_immediate_pi), BR_IMM_W));
   assign jmp_off = PC_W'(sign_extend(32'(bus.jump_immediate_pi), JMP_IMM_W));

   // A halt request consumes the edge, so nothing else may act on it.
   assign advance = bus.clk_en_pi && (state == ST_RUN) && !bus.halt_pi;

   // Next-PC selection and RAS/flag side effects for this edge.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      sel     = SEL_SEQ;
      push    = 1'b0;
      pop     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (advance) begin
         if (bus.ret_pi) begin
            if (ras_empty) begin
               set_unf = 1'b1;
            end else begin
               sel = SEL_RET;
               pop = 1'b1;
            end
         end else if (bus.branch_taken_pi) begin
            sel = SEL_BR;
         end else if (bus.jump_taken_pi) begin
            sel = SEL_JMP;
            if (bus.call_pi) begin
               push    = 1'b1;
               set_ovf = ras_full;
            end
         end
      end

      unique case (sel)
         SEL_RET: pc_next = ras_top;
         SEL_BR:  pc_next = pc_q + br_off;
         SEL_JMP: pc_next = pc_q + jmp_off;
         default: pc_next = pc_seq;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         state <= ST_RUN;
         pc_q  <= PC_W'(RESET_VECTOR);
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (bus.clk_en_pi) begin
         unique case (state)
            ST_RUN: begin
               if (bus.halt_pi) state <= ST_HALTED;
               else             pc_q  <= pc_next;
            end
            default: state <= ST_HALTED;
         endcase
         // A flag set on the same edge as a clear wins over the clear.
         ovf_q <= set_ovf | (ovf_q & ~bus.clear_flags_pi);
         unf_q <= set_unf | (unf_q & ~bus.clear_flags_pi);
      end
   end

   assign bus.pc_po            = pc_q;
   assign bus.halted_po        = (state == ST_HALTED);
   assign bus.ras_count_po     = ras_count;
   assign bus.ras_overflow_po  = ovf_q;
   assign bus.ras_underflow_po = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// -----------------------------------------------------------------------------
// tb_program_counter_ras
// Directed bench for program_counter_ras with hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_program_counter_ras;

   localparam int PC_W      = 16;
   localparam int BR_IMM_W  = 6;
   localparam int JMP_IMM_W = 12;
   localparam int RAS_DEPTH = 4;
   localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   program_counter_ras_if #(
      .PC_W      (PC_W),
      .BR_IMM_W  (BR_IMM_W),
      .JMP_IMM_W (JMP_IMM_W),
      .CNT_W     (CNT_W)
   ) bus ();

   program_counter_ras #(
      .PC_W         (PC_W),
      .INSTR_BYTES  (2),
      .BR_IMM_W     (BR_IMM_W),
      .JMP_IMM_W    (JMP_IMM_W),
      .RAS_DEPTH    (RAS_DEPTH),
      .RESET_VECTOR (0)
   ) dut (
      .clk_pi     (clk),
      .reset_n_pi (reset_n),
      .bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic idle();
      bus.clk_en_pi           = 1'b1;
      bus.halt_pi             = 1'b0;
      bus.branch_taken_pi     = 1'b0;
      bus.branch_immediate_pi = '0;
      bus.jump_taken_pi       = 1'b0;
      bus.jump_immediate_pi   = '0;
      bus.call_pi             = 1'b0;
      bus.ret_pi              = 1'b0;
      bus.clear_flags_pi      = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input logic [11:0] imm, input logic call);
      idle();
      bus.jump_taken_pi     = 1'b1;
      bus.jump_immediate_pi = imm;
      bus.call_pi           = call;
      step();
      idle();
   endtask

   task automatic do_ret();
      idle();
      bus.ret_pi = 1'b1;
      step();
      idle();
   endtask

   task automatic do_branch(input logic [5:0] imm);
      idle();
      bus.branch_taken_pi     = 1'b1;
      bus.branch_immediate_pi = imm;
      step();
      idle();
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      idle();

      // Reset state
      #3;
      check("rst_pc",     32'(bus.pc_po), 32'h0000);
      check("rst_halted", 32'(bus.halted_po), 32'd0);
      check("rst_count",  32'(bus.ras_count_po), 32'd0);
      check("rst_ovf",    32'(bus.ras_overflow_po), 32'd0);
      check("rst_unf",    32'(bus.ras_underflow_po), 32'd0);
      #9;
      reset_n = 1'b1;

      // 1. Sequential stepping, then clock-enable hold
      check("seq0", 32'(bus.pc_po), 32'h0000);
      step(); check("seq1", 32'(bus.pc_po), 32'h0002);
      step(); check("seq2", 32'(bus.pc_po), 32'h0004);
      step(); check("seq3", 32'(bus.pc_po), 32'h0006);
      bus.clk_en_pi = 1'b0;
      bus.jump_taken_pi = 1'b1;
      bus.jump_immediate_pi = 12'h100;
      for (int i = 0; i < 2; i++) begin
         step(); check("hold_en0", 32'(bus.pc_po), 32'h0006);
      end
      idle();
      step(); check("seq4", 32'(bus.pc_po), 32'h0008);

      // 2. Branch, jump, branch-over-jump priority
      do_branch(6'b111100); check("br_neg4", 32'(bus.pc_po), 32'h0004);
      do_jump(12'h7FE, 1'b0); check("jmp_7fe", 32'(bus.pc_po), 32'h0802);
      bus.branch_taken_pi = 1'b1; bus.branch_immediate_pi = 6'd2;
      bus.jump_taken_pi = 1'b1;   bus.jump_immediate_pi = 12'h100;
      step(); idle();
      check("br_wins", 32'(bus.pc_po), 32'h0804);

      // 3. Single call / return (0x804 + sext(0x80C) = 0x0010)
      do_jump(12'h80C, 1'b0); check("to_0010", 32'(bus.pc_po), 32'h0010);
      do_jump(12'h020, 1'b1);
      check("call_pc",  32'(bus.pc_po), 32'h0030);
      check("call_cnt", 32'(bus.ras_count_po), 32'd1);
      step(); step();
      check("seq_0034", 32'(bus.pc_po), 32'h0034);
      do_ret();
      check("ret_pc",  32'(bus.pc_po), 32'h0012);
      check("ret_cnt", 32'(bus.ras_count_po), 32'd0);

      // 4. Overflow, circular overwrite, underflow, flag clear
      do_jump(12'h0EE, 1'b0); check("to_0100", 32'(bus.pc_po), 32'h0100);
      for (int i = 0; i < 4; i++) do_jump(12'h100, 1'b1);
      check("cnt_full", 32'(bus.ras_count_po), 32'd4);
      check("ovf_not_yet", 32'(bus.ras_overflow_po), 32'd0);
      do_jump(12'h100, 1'b1);
      check("call5_pc", 32'(bus.pc_po), 32'h0600);
      check("ovf_set",  32'(bus.ras_overflow_po), 32'd1);
      check("cnt_sat",  32'(bus.ras_count_po), 32'd4);
      do_ret(); check("ret1", 32'(bus.pc_po), 32'h0502);
      do_ret(); check("ret2", 32'(bus.pc_po), 32'h0402);
      do_ret(); check("ret3", 32'(bus.pc_po), 32'h0302);
      do_ret(); check("ret4", 32'(bus.pc_po), 32'h0202);
      check("cnt_empty", 32'(bus.ras_count_po), 32'd0);
      do_ret();
      check("ret_empty_pc", 32'(bus.pc_po), 32'h0204);
      check("unf_set", 32'(bus.ras_underflow_po), 32'd1);
      check("ovf_kept", 32'(bus.ras_overflow_po), 32'd1);
      bus.clear_flags_pi = 1'b1; step(); idle();
      check("clr_ovf", 32'(bus.ras_overflow_po), 32'd0);
      check("clr_unf", 32'(bus.ras_underflow_po), 32'd0);
      check("clr_pc",  32'(bus.pc_po), 32'h0206);
      // Set and clear on the same edge: set wins
      bus.ret_pi = 1'b1; bus.clear_flags_pi = 1'b1; step(); idle();
      check("set_wins", 32'(bus.ras_underflow_po), 32'd1);
      check("set_wins_pc", 32'(bus.pc_po), 32'h0208);
      bus.clear_flags_pi = 1'b1; step(); idle();
      check("clr_again", 32'(bus.ras_underflow_po), 32'd0);

      // 5. Wrap-around (0x20A + sext(0xDF4) = 0xFFFE)
      do_jump(12'hDF4, 1'b0); check("to_fffe", 32'(bus.pc_po), 32'hFFFE);
      step(); check("wrap_up", 32'(bus.pc_po), 32'h0000);
      do_branch(6'b111110); check("wrap_down", 32'(bus.pc_po), 32'hFFFE);

      // 6. Halt, frozen state, asynchronous reset
      do_jump(12'h042, 1'b0); check("to_0040", 32'(bus.pc_po), 32'h0040);
      bus.halt_pi = 1'b1; bus.jump_taken_pi = 1'b1;
      bus.jump_immediate_pi = 12'h010; bus.call_pi = 1'b1;
      step();
      check("halted", 32'(bus.halted_po), 32'd1);
      check("halt_pc", 32'(bus.pc_po), 32'h0040);
      check("halt_cnt", 32'(bus.ras_count_po), 32'd0);
      bus.halt_pi = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.ret_pi = i[0];
         step();
         check("frozen_pc", 32'(bus.pc_po), 32'h0040);
      end
      check("frozen_cnt", 32'(bus.ras_count_po), 32'd0);
      check("frozen_unf", 32'(bus.ras_underflow_po), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_pc",     32'(bus.pc_po), 32'h0000);
      check("arst_halted", 32'(bus.halted_po), 32'd0);
      check("arst_cnt",    32'(bus.ras_count_po), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
